// File: rtl/lfsr_keystream.sv
// lfsr_keystream
// Fibonacci LFSR keystream generator for the encrypt/decrypt datapath.
// A seed load is followed by an optional warm-up phase that discards steps.
// Keystream symbols are then offered to the cipher XOR stage on a valid/ready
// handshake. An all-zero register is trapped in LOCK with a sticky error flag.
//
// Optional build macro: LFSR_TAPLOAD_EN
//   Adds the ldTaps/tapVal ports and a runtime tap register that resets to TAPS.
//   When the macro is undefined, the feedback uses the constant TAPS.
//
// Ports:
//   clk      system clock; all state updates on the rising edge
//   rst      asynchronous, active-high reset
//   ldLFSR   load seed; highest priority
//   ldVal    seed value
//   warmLen  number of discarded steps after a load, sampled with ldLFSR
//   ksReady  consumer accepts ksByte this cycle
//   ldTaps   (LFSR_TAPLOAD_EN only) load the tap register from tapVal
//   tapVal   (LFSR_TAPLOAD_EN only) new tap mask
//   ksValid  ksByte is valid (RUN state and non-zero register)
//   ksByte   keystream symbol, decoded from the LFSR register
//   lfsrVal  current LFSR register
//   ksCount  symbols accepted since the last load (wraps)
//   lockErr  sticky flag: the register was all-zero in WARM or RUN
//   busy     high during warm-up
//
// WIDTH must be a multiple of BYTE_W and at least 2*BYTE_W.

module lfsr_keystream #(
    parameter int unsigned       WIDTH  = 32,
    parameter int unsigned       BYTE_W = 8,
    parameter logic [WIDTH-1:0]  TAPS   = WIDTH'(32'h40001064),
    parameter int unsigned       WARM_W = 8,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ldLFSR,
    input  logic [WIDTH-1:0]  ldVal,
    input  logic [WARM_W-1:0] warmLen,
    input  logic              ksReady,
`ifdef LFSR_TAPLOAD_EN
    input  logic              ldTaps,
    input  logic [WIDTH-1:0]  tapVal,
`endif
    output logic              ksValid,
    output logic [BYTE_W-1:0] ksByte,
    output logic [WIDTH-1:0]  lfsrVal,
    output logic [CNT_W-1:0]  ksCount,
    output logic              lockErr,
    output logic              busy
);

    localparam int unsigned NSLICE = WIDTH / BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   lfsr, lfsr_nxt;
    logic [WIDTH-1:0]   lfsr_step;
    logic [WIDTH-1:0]   taps_cur;
    logic [WARM_W-1:0]  warm_cnt, warm_cnt_nxt;
    logic [CNT_W-1:0]   ks_count, ks_count_nxt;
    logic               lock_err, lock_err_nxt;
    logic               fb_bit;
    logic               lfsr_zero;
    logic               ks_valid_c;
    logic [BYTE_W-1:0]  ks_byte_c;

    // Feedback tap source: runtime register or build-time constant
`ifdef LFSR_TAPLOAD_EN
    logic [WIDTH-1:0] tap_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_reg <= TAPS;
        end else if (ldTaps) begin
            tap_reg <= tapVal;
        end
    end

    assign taps_cur = tap_reg;
`else
    assign taps_cur = TAPS;
`endif

    // One Fibonacci step: shift left, feedback enters at bit 0
    assign fb_bit    = ^(lfsr & taps_cur);
    assign lfsr_step = {lfsr[WIDTH-2:0], fb_bit};
    assign lfsr_zero = (lfsr == '0);

    // Symbol decode: XOR of all slices, with the top slice MSB forced to 1.
    // Replacing that bit before the XOR is the same as flipping the result
    // MSB by the inverse of the original bit.
    always_comb begin
        ks_byte_c = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            ks_byte_c = ks_byte_c ^ lfsr[i*BYTE_W +: BYTE_W];
        end
        ks_byte_c[BYTE_W-1] = ks_byte_c[BYTE_W-1] ^ ~lfsr[WIDTH-1];
    end

    assign ks_valid_c = (state == RUN) && !lfsr_zero;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= '0;
            warm_cnt <= '0;
            ks_count <= '0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            warm_cnt <= warm_cnt_nxt;
            ks_count <= ks_count_nxt;
            lock_err <= lock_err_nxt;
        end
    end

    // Next-state and datapath update; a seed load overrides everything else
    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        warm_cnt_nxt = warm_cnt;
        ks_count_nxt = ks_count;
        lock_err_nxt = lock_err;

        if (ldLFSR) begin
            lfsr_nxt     = ldVal;
            ks_count_nxt = '0;
            lock_err_nxt = 1'b0;
            warm_cnt_nxt = warmLen;
            state_nxt    = (warmLen != '0) ? WARM : RUN;
        end else begin
            case (state)
                IDLE: begin
                end
                WARM: begin
                    if (lfsr_zero) begin
                        state_nxt    = LOCK;
                        lock_err_nxt = 1'b1;
                    end else begin
                        lfsr_nxt     = lfsr_step;
                        warm_cnt_nxt = warm_cnt - WARM_W'(1);
                        // Last discarded step; <= also guards a zero count
                        if (warm_cnt <= WARM_W'(1)) begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (lfsr_zero) begin
                        state_nxt    = LOCK;
                        lock_err_nxt = 1'b1;
                    end else if (ksReady) begin
                        lfsr_nxt     = lfsr_step;
                        ks_count_nxt = ks_count + CNT_W'(1);
                    end
                end
                LOCK: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign ksValid = ks_valid_c;
    assign ksByte  = ks_byte_c;
    assign lfsrVal = lfsr;
    assign ksCount = ks_count;
    assign lockErr = lock_err;
    assign busy    = (state == WARM);

endmodule

// File: tb/tb_lfsr_keystream.sv
// Directed testbench for lfsr_keystream with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lfsr_keystream;

    logic        clk;
    logic        rst;
    logic        ldLFSR;
    logic [31:0] ldVal;
    logic [7:0]  warmLen;
    logic        ksReady;
`ifdef LFSR_TAPLOAD_EN
    logic        ldTaps;
    logic [31:0] tapVal;
`endif
    logic        ksValid;
    logic [7:0]  ksByte;
    logic [31:0] lfsrVal;
    logic [15:0] ksCount;
    logic        lockErr;
    logic        busy;

    int n_asserts = 0;
    int n_fails   = 0;

    lfsr_keystream dut (
        .clk     (clk),
        .rst     (rst),
        .ldLFSR  (ldLFSR),
        .ldVal   (ldVal),
        .warmLen (warmLen),
        .ksReady (ksReady),
`ifdef LFSR_TAPLOAD_EN
        .ldTaps  (ldTaps),
        .tapVal  (tapVal),
`endif
        .ksValid (ksValid),
        .ksByte  (ksByte),
        .lfsrVal (lfsrVal),
        .ksCount (ksCount),
        .lockErr (lockErr),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step with taps 30,12,6,5,2
    function automatic logic [31:0] ref_step(input logic [31:0] l);
        logic f;
        f = l[30] ^ l[12] ^ l[6] ^ l[5] ^ l[2];
        return {l[30:0], f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(negedge clk);
    endtask

    logic [31:0] model;

    initial begin
        rst     = 1'b1;
        ldLFSR  = 1'b0;
        ldVal   = '0;
        warmLen = '0;
        ksReady = 1'b0;
`ifdef LFSR_TAPLOAD_EN
        ldTaps  = 1'b0;
        tapVal  = '0;
`endif
        step_cycle();
        step_cycle();
        chk("rst_lfsr",    lfsrVal, 32'h0);
        chk("rst_valid",   32'(ksValid), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_lockerr", 32'(lockErr), 32'h0);
        chk("rst_count",   32'(ksCount), 32'h0);
        rst = 1'b0;
        step_cycle();
        chk("idle_valid",  32'(ksValid), 32'h0);

        // Seed 1, no warm-up, consumer ready
        ldLFSR = 1'b1; ldVal = 32'h1; warmLen = 8'd0; ksReady = 1'b1;
        step_cycle();
        ldLFSR = 1'b0;
        chk("t1_valid", 32'(ksValid), 32'h1);
        chk("t1_byte",  32'(ksByte), 32'h81);
        chk("t1_lfsr",  lfsrVal, 32'h1);
        chk("t1_count", 32'(ksCount), 32'h0);
        step_cycle();
        ksReady = 1'b0;
        chk("t1_acc_lfsr",  lfsrVal, 32'h2);
        chk("t1_acc_byte",  32'(ksByte), 32'h82);
        chk("t1_acc_count", 32'(ksCount), 32'h1);

        // Stall: ksReady low for 5 cycles holds the symbol
        repeat (5) step_cycle();
        chk("hold_lfsr",  lfsrVal, 32'h2);
        chk("hold_byte",  32'(ksByte), 32'h82);
        chk("hold_count", 32'(ksCount), 32'h1);
        chk("hold_valid", 32'(ksValid), 32'h1);

        // Seed 4 with one warm-up step
        ldLFSR = 1'b1; ldVal = 32'h4; warmLen = 8'd1;
        step_cycle();
        ldLFSR = 1'b0;
        chk("t2_busy",  32'(busy), 32'h1);
        chk("t2_valid", 32'(ksValid), 32'h0);
        chk("t2_count", 32'(ksCount), 32'h0);
        step_cycle();
        chk("t2_busy_lo", 32'(busy), 32'h0);
        chk("t2_lfsr",    lfsrVal, 32'h9);
        chk("t2_byte",    32'(ksByte), 32'h89);
        chk("t2_valid_hi", 32'(ksValid), 32'h1);

        // All-zero seed traps in LOCK
        ldLFSR = 1'b1; ldVal = 32'h0; warmLen = 8'd0; ksReady = 1'b1;
        step_cycle();
        ldLFSR = 1'b0;
        chk("z_valid0",   32'(ksValid), 32'h0);
        chk("z_lockerr0", 32'(lockErr), 32'h0);
        step_cycle();
        chk("z_lockerr1", 32'(lockErr), 32'h1);
        step_cycle();
        step_cycle();
        chk("lock_lockerr", 32'(lockErr), 32'h1);
        chk("lock_valid",   32'(ksValid), 32'h0);
        chk("lock_lfsr",    lfsrVal, 32'h0);
        chk("lock_count",   32'(ksCount), 32'h0);
        ldLFSR = 1'b1; ldVal = 32'h1; ksReady = 1'b0;
        step_cycle();
        ldLFSR = 1'b0;
        chk("unlock_lockerr", 32'(lockErr), 32'h0);
        chk("unlock_valid",   32'(ksValid), 32'h1);
        chk("unlock_byte",    32'(ksByte), 32'h81);

        // Long warm-up interrupted by a reload halfway through
        ldLFSR = 1'b1; ldVal = 32'h1; warmLen = 8'd200;
        step_cycle();
        ldLFSR = 1'b0;
        model = 32'h1;
        repeat (100) begin
            step_cycle();
            model = ref_step(model);
        end
        chk("warm_busy",  32'(busy), 32'h1);
        chk("warm_valid", 32'(ksValid), 32'h0);
        chk("warm_lfsr",  lfsrVal, model);
        ldLFSR = 1'b1; ldVal = 32'h4; warmLen = 8'd0;
        step_cycle();
        ldLFSR = 1'b0;
        chk("rl_busy",  32'(busy), 32'h0);
        chk("rl_valid", 32'(ksValid), 32'h1);
        chk("rl_lfsr",  lfsrVal, 32'h4);
        chk("rl_count", 32'(ksCount), 32'h0);

        // Asynchronous reset in the middle of RUN
        ksReady = 1'b1;
        step_cycle();
        step_cycle();
        chk("pre_rst_count", 32'(ksCount), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst_lfsr",    lfsrVal, 32'h0);
        chk("arst_valid",   32'(ksValid), 32'h0);
        chk("arst_count",   32'(ksCount), 32'h0);
        chk("arst_busy",    32'(busy), 32'h0);
        chk("arst_lockerr", 32'(lockErr), 32'h0);
        ksReady = 1'b0;
        step_cycle();
        rst = 1'b0;

        // Counter wrap: 65535 accepts then one more
        ldLFSR = 1'b1; ldVal = 32'h1; warmLen = 8'd0; ksReady = 1'b1;
        step_cycle();
        ldLFSR = 1'b0;
        model = 32'h1;
        repeat (65535) begin
            step_cycle();
            model = ref_step(model);
        end
        chk("wrap_pre_count", 32'(ksCount), 32'hFFFF);
        chk("wrap_pre_lfsr",  lfsrVal, model);
        step_cycle();
        ksReady = 1'b0;
        model = ref_step(model);
        chk("wrap_count",   32'(ksCount), 32'h0);
        chk("wrap_lfsr",    lfsrVal, model);
        chk("wrap_valid",   32'(ksValid), 32'h1);
        chk("wrap_lockerr", 32'(lockErr), 32'h0);
        chk("wrap_busy",    32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
